ls_sequencer: RTL and testbench

LS_SEQUENCER -- requirements
Module: ls_sequencer

---
 rtl/ls_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_ls_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_sequencer.sv
// ls_sequencer: APB-master sequencer that loads NumCoeffs coefficient
// registers, pulses start_work, streams FramePixels pixels into the datapath
// and then clears start_work.
// Optional build macro: LS_SEQ_PREADY_EN adds a PREADY input and stretches
// every APB access phase until PREADY is high.
module ls_sequencer #(
  parameter int Amba_Addr_Depth = 20,
  parameter int Amba_Word       = 24,
  parameter int PixelPrecision  = 8,
  parameter int NumCoeffs       = 7,
  parameter int FramePixels     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  output logic                       busy,
  output logic                       done,
  output logic                       underrun,
  input  logic [Amba_Word-1:0]       coeff_data,
  input  logic                       coeff_valid,
  output logic                       coeff_ready,
  input  logic [PixelPrecision-1:0]  pix_data,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [Amba_Addr_Depth-1:0] PADDR,
  output logic [Amba_Word-1:0]       PWDATA,
`ifdef LS_SEQ_PREADY_EN
  input  logic                       PREADY,
`endif
  output logic [PixelPrecision-1:0]  ImInput
);

  typedef enum logic [2:0] {
    IDLE,
    CFG_SETUP,
    CFG_ACCESS,
    START_SETUP,
    START_ACCESS,
    STREAM,
    STOP_SETUP,
    STOP_ACCESS
  } state_t;

  localparam logic [15:0]                LastPix   = 16'(FramePixels - 1);
  localparam logic [Amba_Addr_Depth-1:0] LastCoeff = Amba_Addr_Depth'(NumCoeffs);

  state_t                      state, next_state;
  logic [Amba_Addr_Depth-1:0]  paddr_q, paddr_d;
  logic [Amba_Word-1:0]        pwdata_q, pwdata_d;
  logic [15:0]                 pix_cnt, pix_cnt_d;
  logic                        done_q, done_d;
  logic                        und_q, und_d;
  logic [PixelPrecision-1:0]   im_q, im_d;
  logic                        access_ok;

`ifdef LS_SEQ_PREADY_EN
  assign access_ok = PREADY;
`else
  assign access_ok = 1'b1;
`endif

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign underrun = und_q;
  assign ImInput  = im_q;
  assign PADDR    = paddr_q;
  assign PWRITE   = PSEL;

  // State and datapath registers; everything clears immediately on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pix_cnt  <= '0;
      done_q   <= 1'b0;
      und_q    <= 1'b0;
      im_q     <= '0;
    end else begin
      state    <= next_state;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pix_cnt  <= pix_cnt_d;
      done_q   <= done_d;
      und_q    <= und_d;
      im_q     <= im_d;
    end
  end

  // Next-state, APB phase outputs, handshakes and register updates.
  // paddr_q doubles as the coefficient index k. In CFG_SETUP the incoming
  // coefficient is forwarded straight onto PWDATA so the setup phase costs no
  // extra cycle; the same value is latched for the access phase.
  always_comb begin
    next_state  = state;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pix_cnt_d   = pix_cnt;
    done_d      = 1'b0;
    und_d       = und_q;
    im_d        = im_q;
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    PWDATA      = pwdata_q;
    coeff_ready = 1'b0;
    pix_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          next_state = CFG_SETUP;
          paddr_d    = Amba_Addr_Depth'(1);
          und_d      = 1'b0;
        end
      end
      CFG_SETUP: begin
        coeff_ready = 1'b1;
        if (coeff_valid) begin
          PSEL       = 1'b1;
          PWDATA     = coeff_data;
          pwdata_d   = coeff_data;
          next_state = CFG_ACCESS;
        end
      end
      CFG_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (access_ok) begin
          if (paddr_q == LastCoeff) begin
            next_state = START_SETUP;
            paddr_d    = '0;
            pwdata_d   = '1;
          end else begin
            next_state = CFG_SETUP;
            paddr_d    = paddr_q + Amba_Addr_Depth'(1);
          end
        end
      end
      START_SETUP: begin
        PSEL       = 1'b1;
        next_state = START_ACCESS;
      end
      START_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (access_ok) begin
          next_state = STREAM;
          pix_cnt_d  = '0;
        end
      end
      STREAM: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          im_d = pix_data;
        end else begin
          im_d  = '0;
          und_d = 1'b1;
        end
        if (pix_cnt == LastPix) begin
          pix_cnt_d  = '0;
          pwdata_d   = '0;
          next_state = STOP_SETUP;
        end else begin
          pix_cnt_d = pix_cnt + 16'd1;
        end
      end
      STOP_SETUP: begin
        PSEL       = 1'b1;
        next_state = STOP_ACCESS;
      end
      STOP_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (access_ok) begin
          done_d     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ls_sequencer.sv
// Self-checking bench for ls_sequencer (NumCoeffs=2, FramePixels=4):
// directed frame table, hand-written reset sequence, randomized frames.
module tb_ls_sequencer;

  localparam int AW = 20;
  localparam int DW = 24;
  localparam int PP = 8;
  localparam int N  = 2;
  localparam int FP = 4;
`ifdef LS_SEQ_PREADY_EN
  localparam int STALLS = 2;
`else
  localparam int STALLS = 0;
`endif

  logic          clk, rst, go;
  logic          busy, done, underrun;
  logic [DW-1:0] coeff_data;
  logic          coeff_valid, coeff_ready;
  logic [PP-1:0] pix_data;
  logic          pix_valid, pix_ready;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic [PP-1:0] ImInput;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;

  // Slave holds off the start_work=1 access for STALLS cycles.
  assign PREADY = !(PSEL && PENABLE && PADDR == '0 && PWDATA == '1 && stall_cnt < STALLS);

  ls_sequencer #(
    .Amba_Addr_Depth(AW),
    .Amba_Word(DW),
    .PixelPrecision(PP),
    .NumCoeffs(N),
    .FramePixels(FP)
  ) dut (
    .clk(clk), .rst(rst), .go(go),
    .busy(busy), .done(done), .underrun(underrun),
    .coeff_data(coeff_data), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef LS_SEQ_PREADY_EN
    .PREADY(PREADY),
`endif
    .ImInput(ImInput)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0][DW-1:0] c;
    logic [1:0][3:0]    g;
    logic [3:0][PP-1:0] px;
    logic [3:0]         pv;
    logic               und;
    logic [3:0][PP-1:0] im;
  } vec_t;

  // Current frame stimulus and expectations
  logic [DW-1:0] cur_c [N];
  int            cur_g [N];
  logic [PP-1:0] cur_px[FP];
  logic          cur_pv[FP];
  logic [PP-1:0] exp_im[FP];
  logic          exp_und;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input string tag);
    logic [31:0] wa[$], wd[$], imq[$];
    logic [31:0] su_a, su_d;
    logic [31:0] ea, ed;
    int ci, gcnt, pidx, busy_cyc, cyc, en_start, apb_bad, gap_bad, excl_bad, exp_busy;
    bit prev_pixr, seen_done, stalled;
    su_a = '0; su_d = '0;
    ci = 0; gcnt = 0; pidx = 0; busy_cyc = 0; cyc = 0; en_start = 0;
    apb_bad = 0; gap_bad = 0; excl_bad = 0;
    prev_pixr = 0; seen_done = 0;
    stall_cnt = 0;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    check({tag, "/underrun_clear"}, underrun, 0);
    while (!seen_done && cyc < 300) begin
      coeff_valid = (ci < N) ? (gcnt >= cur_g[ci]) : 1'b0;
      coeff_data  = (ci < N) ? cur_c[ci] : DW'($urandom);
      pix_valid   = (pidx < FP) ? cur_pv[pidx] : 1'b0;
      pix_data    = (pidx < FP) ? cur_px[pidx] : PP'($urandom);
      @(negedge clk);
      if (prev_pixr) imq.push_back(32'(ImInput));
      if (busy) busy_cyc++;
      seen_done = done;
      if (PSEL && !PENABLE) begin
        su_a = 32'(PADDR);
        su_d = 32'(PWDATA);
        if (!PWRITE) apb_bad++;
      end
      if (PENABLE) begin
        if (!PSEL || !PWRITE || 32'(PADDR) != su_a || 32'(PWDATA) != su_d) apb_bad++;
        if (PADDR == '0 && PWDATA == '1) en_start++;
        if (PREADY) begin
          wa.push_back(32'(PADDR));
          wd.push_back(32'(PWDATA));
        end
      end
      if (coeff_ready && !coeff_valid && PSEL) gap_bad++;
      if (coeff_ready && pix_ready) excl_bad++;
      stalled = PSEL && PENABLE && !PREADY;
      if (coeff_ready && coeff_valid) begin
        ci++;
        gcnt = 0;
      end else if (coeff_ready) begin
        gcnt++;
      end
      prev_pixr = pix_ready;
      if (pix_ready) pidx++;
      @(posedge clk); #1;
      if (stalled) stall_cnt++;
      cyc++;
    end
    coeff_valid = 1'b0;
    pix_valid   = 1'b0;
    check({tag, "/done_seen"}, seen_done, 1);
    exp_busy = 2 * N + 2 + STALLS + FP + 2;
    for (int i = 0; i < N; i++) exp_busy += cur_g[i];
    check({tag, "/busy_cycles"}, busy_cyc, exp_busy);
    check({tag, "/apb_protocol"}, apb_bad, 0);
    check({tag, "/psel_in_gap"}, gap_bad, 0);
    check({tag, "/ready_exclusive"}, excl_bad, 0);
    check({tag, "/coeffs_taken"}, ci, N);
    check({tag, "/start_penable_cycles"}, en_start, 1 + STALLS);
    check({tag, "/write_count"}, wa.size(), N + 2);
    for (int i = 0; i < N + 2 && i < wa.size(); i++) begin
      if (i < N) begin
        ea = 32'(i + 1);
        ed = 32'(cur_c[i]);
      end else begin
        ea = 0;
        ed = (i == N) ? 32'h00FF_FFFF : 32'h0;
      end
      check({tag, $sformatf("/waddr%0d", i)}, wa[i], ea);
      check({tag, $sformatf("/wdata%0d", i)}, wd[i], ed);
    end
    check({tag, "/pixel_count"}, imq.size(), FP);
    for (int i = 0; i < FP && i < imq.size(); i++)
      check({tag, $sformatf("/im%0d", i)}, imq[i], 32'(exp_im[i]));
    check({tag, "/underrun"}, underrun, exp_und);
    @(negedge clk);
    check({tag, "/done_one_cycle"}, done, 0);
    check({tag, "/idle_busy"}, busy, 0);
    check({tag, "/im_hold"}, ImInput, 32'(exp_im[FP-1]));
    check({tag, "/underrun_sticky"}, underrun, exp_und);
    @(posedge clk); #1;
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < N; i++) begin
      cur_c[i] = v.c[i];
      cur_g[i] = int'(v.g[i]);
    end
    for (int i = 0; i < FP; i++) begin
      cur_px[i] = v.px[i];
      cur_pv[i] = v.pv[i];
      exp_im[i] = v.im[i];
    end
    exp_und = v.und;
  endtask

  // Randomized frame with expectations from the behavioural rules:
  // missing pixel -> 0 on ImInput and a sticky underrun.
  task automatic random_frame();
    exp_und = 1'b0;
    for (int i = 0; i < N; i++) begin
      cur_c[i] = DW'($urandom);
      cur_g[i] = $urandom_range(0, 3);
    end
    for (int i = 0; i < FP; i++) begin
      cur_px[i] = PP'($urandom);
      cur_pv[i] = ($urandom_range(0, 3) != 0);
      exp_im[i] = cur_pv[i] ? cur_px[i] : '0;
      if (!cur_pv[i]) exp_und = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/done"}, done, 0);
    check({tag, "/underrun"}, underrun, 0);
    check({tag, "/coeff_ready"}, coeff_ready, 0);
    check({tag, "/pix_ready"}, pix_ready, 0);
    check({tag, "/psel"}, PSEL, 0);
    check({tag, "/penable"}, PENABLE, 0);
    check({tag, "/pwrite"}, PWRITE, 0);
    check({tag, "/paddr"}, PADDR, 0);
    check({tag, "/pwdata"}, PWDATA, 0);
    check({tag, "/im"}, ImInput, 0);
  endtask

  vec_t vecs[4];

  initial begin
    bit hit;
    vecs[0].c = {24'h0000B0, 24'h00000A}; vecs[0].g = {4'd0, 4'd0};
    vecs[0].px = {8'h1A, 8'h8C, 8'hFF, 8'h8C}; vecs[0].pv = 4'b1111;
    vecs[0].und = 1'b0; vecs[0].im = {8'h1A, 8'h8C, 8'hFF, 8'h8C};
    vecs[1].c = {24'hABCDEF, 24'h123456}; vecs[1].g = {4'd0, 4'd3};
    vecs[1].px = {8'h04, 8'h03, 8'h02, 8'h01}; vecs[1].pv = 4'b1111;
    vecs[1].und = 1'b0; vecs[1].im = {8'h04, 8'h03, 8'h02, 8'h01};
    vecs[2].c = {24'hFFFFFE, 24'h000001}; vecs[2].g = {4'd1, 4'd0};
    vecs[2].px = {8'h1A, 8'h8C, 8'hFF, 8'h8C}; vecs[2].pv = 4'b1011;
    vecs[2].und = 1'b1; vecs[2].im = {8'h1A, 8'h00, 8'hFF, 8'h8C};
    vecs[3].c = {24'hAAAAAA, 24'h555555}; vecs[3].g = {4'd2, 4'd2};
    vecs[3].px = {8'h44, 8'h33, 8'h22, 8'h11}; vecs[3].pv = 4'b0000;
    vecs[3].und = 1'b1; vecs[3].im = {8'h00, 8'h00, 8'h00, 8'h00};

    rst = 1'b1; go = 1'b0;
    coeff_valid = 1'b0; coeff_data = '0;
    pix_valid = 1'b0; pix_data = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      load_vec(vecs[i]);
      run_frame($sformatf("vec%0d", i));
    end

    for (int f = 0; f < 12; f++) begin
      random_frame();
      run_frame($sformatf("rand%0d", f));
    end

    // Reset asserted mid-cycle while the first coefficient write is in its access phase
    load_vec(vecs[0]);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    coeff_valid = 1'b1;
    coeff_data = cur_c[0];
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (PENABLE && PADDR == AW'(1)) hit = 1;
    end
    check("midreset/reach_cfg_access", hit, 1);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    coeff_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_im[FP-1] = vecs[0].im[FP-1];
    run_frame("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
